// File: rtl/button_processor_pkg.sv
// Shared types, board defaults and elaboration-time helpers for the button
// processor and its per-channel slice.
package button_processor_pkg;

  // Defaults sized for a 50 MHz board clock: a 0.5 ms sample period and
  // 150 consecutive high samples give roughly 75 ms of debounce.
  localparam int DEFAULT_SAMPLE_COUNT_MAX = 25000;
  localparam int DEFAULT_PULSE_COUNT_MAX  = 150;
  localparam int DEFAULT_LONG_TICKS       = 1000;
  localparam int DEFAULT_REPEAT_TICKS     = 200;

  // Per-channel hold tracking: idle, held but not yet long, long (repeating).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_processor_if.sv
// Button bundle: raw inputs and repeat enables in, debounced level and event
// pulses out. The processor side uses the slave modport.
interface button_processor_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] repeat_en;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] long_pulse;
  logic [WIDTH-1:0] repeat_pulse;

  modport master (
    output in, repeat_en,
    input  pressed, press_pulse, release_pulse, long_pulse, repeat_pulse
  );

  modport slave (
    input  in, repeat_en,
    output pressed, press_pulse, release_pulse, long_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_processor_channel.sv
// One button channel: 2-flop synchroniser, tick-sampled saturating debounce
// counter, registered level/edge outputs and the long-press/auto-repeat FSM.
module button_channel
  import button_processor_pkg::*;
#(
  parameter int PULSE_COUNT_MAX = DEFAULT_PULSE_COUNT_MAX,
  parameter int LONG_TICKS      = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS    = DEFAULT_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic in,
  input  logic repeat_en,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = clog2(PULSE_COUNT_MAX + 1);
  localparam int HW = clog2(max_int(LONG_TICKS, REPEAT_TICKS) + 1);
  localparam logic [DW-1:0] DEB_MAX     = DW'(PULSE_COUNT_MAX);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

  logic          sync_meta;
  logic          sync_in;
  logic [DW-1:0] deb_cnt;
  logic          deb;
  logic          deb_rise;
  logic          hold_tick;
  logic [HW-1:0] hold_cnt;
  hold_state_t   state;

  // Two-flop synchroniser for the asynchronous button input.
  // NOTE: every clocked block uses non-blocking assignments so flops sample
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_in   <= 1'b0;
    end else begin
      sync_meta <= in;
      sync_in   <= sync_meta;
    end
  end

  // Debounce: count consecutive high samples, saturate, clear on a low sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
    end else if (tick) begin
      if (!sync_in)             deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign deb      = (deb_cnt == DEB_MAX);
  assign deb_rise = deb & ~pressed;
  // A tick that samples the button low is the tick that releases it, so it
  // never advances the hold counter: release wins over a threshold.
  assign hold_tick = tick & sync_in;

  // Registered debounced level and its edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      pressed       <= deb;
      press_pulse   <= deb & ~pressed;
      release_pulse <= ~deb & pressed;
    end
  end

  // Hold FSM: time the hold in sample ticks, fire long then repeat pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle so each lasts one clk.
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      if (!deb) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (deb_rise) begin
              state    <= HELD;
              hold_cnt <= '0;
            end
          end
          HELD: begin
            if (hold_tick) begin
              if (hold_cnt == LONG_LAST) begin
                long_pulse <= 1'b1;
                hold_cnt   <= '0;
                state      <= LONG;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          LONG: begin
            if (hold_tick) begin
              if (hold_cnt == REPEAT_LAST) begin
                repeat_pulse <= repeat_en;
                hold_cnt     <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_processor.sv
// Multi-channel button front end: one shared debounce sample-tick generator
// feeding WIDTH independent button channels.
module button_processor
  import button_processor_pkg::*;
#(
  parameter int WIDTH            = 1,
  parameter int SAMPLE_COUNT_MAX = DEFAULT_SAMPLE_COUNT_MAX,
  parameter int PULSE_COUNT_MAX  = DEFAULT_PULSE_COUNT_MAX,
  parameter int LONG_TICKS       = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS     = DEFAULT_REPEAT_TICKS
) (
  input logic                clk,
  input logic                rst_n,
  button_processor_if.slave  bus
);

  localparam int TW = clog2(SAMPLE_COUNT_MAX);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_COUNT_MAX - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  // Free-running sample counter, 0..SAMPLE_COUNT_MAX-1, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_channel #(
      .PULSE_COUNT_MAX (PULSE_COUNT_MAX),
      .LONG_TICKS      (LONG_TICKS),
      .REPEAT_TICKS    (REPEAT_TICKS)
    ) u_channel (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .in            (bus.in[i]),
      .repeat_en     (bus.repeat_en[i]),
      .pressed       (bus.pressed[i]),
      .press_pulse   (bus.press_pulse[i]),
      .release_pulse (bus.release_pulse[i]),
      .long_pulse    (bus.long_pulse[i]),
      .repeat_pulse  (bus.repeat_pulse[i])
    );
  end

endmodule

// File: doc/button_processor.md
Name: button_processor

Overview:
- Multi-channel button front end and next-generation button input chain: synchroniser, debouncer, press/release edge detection.
- Adds per-channel long-press detection and auto-repeat, with repeat enabled per channel at runtime.
- Sits between board push-buttons/switches and control FSMs (UART/CPU MMIO, LED/UI logic).
- One shared sample-tick generator serves all channels, so many channels cost only per-channel counters.

Parameters:
- WIDTH, 1, number of independent button channels.
- SAMPLE_COUNT_MAX, 25000, clk cycles between debounce sample ticks (>=2).
- PULSE_COUNT_MAX, 150, consecutive high samples required to declare a press (>=1).
- LONG_TICKS, 1000, sample ticks held after press before long_pulse fires (>=1).
- REPEAT_TICKS, 200, sample ticks between auto-repeat pulses after long press (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset; all state cleared while low.
- in  in  WIDTH  raw asynchronous button inputs.
- repeat_en  in  WIDTH  per-channel auto-repeat enable (synchronous to clk).
- pressed  out  WIDTH  debounced level.
- press_pulse  out  WIDTH  1-cycle pulse on debounced rising edge.
- release_pulse  out  WIDTH  1-cycle pulse on debounced falling edge.
- long_pulse  out  WIDTH  1-cycle pulse when hold reaches LONG_TICKS.
- repeat_pulse  out  WIDTH  1-cycle auto-repeat pulses.

Behaviour:
- Reset: every output 0; sync flops, tick counter, per-channel counters and state cleared. Reset is asynchronous, active-low; deassertion is synchronised externally.
- Sync: 2-flop synchroniser per bit; sync_in lags in by 2 clk.
- Tick generator:
  - Counter runs 0..SAMPLE_COUNT_MAX-1 and wraps.
  - tick is high for the single cycle the counter equals SAMPLE_COUNT_MAX-1.
  - First tick occurs SAMPLE_COUNT_MAX cycles after reset release.
- Debounce, per channel: saturating count, width clog2(PULSE_COUNT_MAX+1).
  - On tick with sync_in=1: increment, saturating at PULSE_COUNT_MAX.
  - On tick with sync_in=0: clear to 0.
  - No change between ticks.
  - deb = (count == PULSE_COUNT_MAX).
- Registered outputs, updated every clk:
  - pressed <= deb.
  - press_pulse <= deb & ~pressed.
  - release_pulse <= ~deb & pressed.
  - press_pulse is high exactly in the first cycle pressed is high. release_pulse is high in the first cycle pressed is low.
- Hold FSM per channel, states IDLE, HELD, LONG:
  - IDLE -> HELD on deb rising; hold counter cleared.
  - HELD: increment hold counter on each tick while deb. When the counter reaches LONG_TICKS, long_pulse is high for 1 cycle, the counter clears, and the FSM goes to LONG.
  - LONG: increment on tick. When the counter reaches REPEAT_TICKS, clear it; repeat_pulse is high for 1 cycle only if repeat_en=1 that cycle.
  - Any state -> IDLE in the cycle deb falls; counters cleared; no long/repeat pulse in that cycle.
  - Hold counter width clog2(max(LONG_TICKS,REPEAT_TICKS)+1); it never wraps.
- Simultaneous events:
  - Channels are fully independent; any combination may pulse in the same cycle.
  - long_pulse and repeat_pulse never coincide on one channel.
  - If release and a counter-threshold tick coincide, release wins: no long/repeat pulse.
- repeat_en toggling only gates repeat_pulse; counting continues regardless.
- Reset mid-press: outputs drop to 0 immediately with no release_pulse. After rst_n rises, a still-held button re-debounces and produces a fresh press_pulse.

Decomposition:
- Shared constants/include: clog2 function, default timing constants for 50 MHz board (SAMPLE_COUNT_MAX/PULSE_COUNT_MAX defaults), FSM state encodings IDLE=2'd0, HELD=2'd1, LONG=2'd2.
- Natural sub-module: button_channel.
  - Contains one channel's synchroniser, debounce counter, output registers and hold FSM.
  - Inputs: clk, rst_n, tick, in bit, repeat_en bit.
  - Instantiated WIDTH times via generate.
  - Top level holds only the tick generator.

Test Plan (SAMPLE_COUNT_MAX=4, PULSE_COUNT_MAX=3, LONG_TICKS=5, REPEAT_TICKS=2, WIDTH=2):
- Reset values: hold rst_n=0, toggle in -> all outputs 0; release rst_n, in=0 for 50 cycles -> outputs remain 0.
- Clean press: in[0]=1 held -> pressed[0] rises 3 ticks after sync_in seen (within 12..16 cycles of in edge); press_pulse[0] high exactly 1 cycle; channel 1 silent.
- Bounce rejection: in[0] toggles high for 1 tick then low, repeated 10 times -> no press_pulse, pressed stays 0.
- Long press + repeat: hold in[0] with repeat_en[0]=1 -> long_pulse 5 ticks (20 cycles) after pressed rises; repeat_pulse every 2 ticks (8 cycles) thereafter. With repeat_en[0]=0 -> long_pulse only, no repeats.
- Release: drop in[0] during LONG -> pressed falls on next tick + 1 cycle; release_pulse 1 cycle; no further long/repeat pulses; re-press restarts from HELD.
- Simultaneous + reset mid-press: press both channels in same cycle -> identical simultaneous press_pulse[1:0]=2'b11. Assert rst_n=0 while held -> outputs 0 asynchronously; release reset with buttons held -> fresh press_pulse on both.
